shift_sequencer: RTL and testbench
==================================

Name: shift_sequencer

Overview:
Multi-cycle controller that performs variable-distance logical shifts by iterating a single-bit shift step, one bit per clock.
Accepts a job (data, amount, direction) over a valid/ready handshake, sequences the steps, then holds the result until the consumer takes it.
Sits in front of the 4-bit shift datapath and lets a narrow one-step shifter serve arbitrary shift distances.

Parameters:
WIDTH, 4, data width in bits
SHAMT_W, 3, width of shift-amount input (amounts 0..2^SHAMT_W-1)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  job request
in_ready  output  1  controller can accept a job
in_data  input  WIDTH  operand
in_amt  input  SHAMT_W  shift distance
in_dir  input  1  0 = left shift, 1 = right shift
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_data  output  WIDTH  shifted result
busy  output  1  high in SHIFT or DONE

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - state = IDLE; out_valid = 0; out_data = 0; busy = 0; count = 0.
  - in_ready = (state == IDLE) & ~rst, so it reads 0 while rst is high.
- States: IDLE, SHIFT, DONE (2-bit encoding).
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch in_data into the working register and latch in_dir.
  - Effective count n = min(in_amt, WIDTH).
  - If n == 0, go to DONE; else go to SHIFT with count = n.
- SHIFT:
  - Each cycle, working register <= one-bit shift of itself, zero-filled (left: {r[WIDTH-2:0],0}; right: {0,r[WIDTH-1:1]}).
  - count decrements each cycle.
  - The step taken when count == 1 is the last one; next state is DONE.
- DONE:
  - out_valid = 1; out_data = working register, held stable.
  - When out_ready is high, go to IDLE.
- Latency: out_valid rises n+1 cycles after the accepting edge (1 cycle for n = 0). Maximum is WIDTH+1 = 5 cycles.
- Amount saturation: amounts >= WIDTH clamp to WIDTH iterations and yield all-zeros.
- No overlap:
  - in_ready is 0 in SHIFT and DONE.
  - in_valid in those states is ignored, and inputs are not sampled.
  - A job presented in the same cycle as the DONE->IDLE handoff is accepted on the following cycle.
- out_data stays 0 until the first result; afterwards it holds the last result through IDLE.
- Reset mid-operation: rst in any state forces IDLE on the next edge. The partial result is discarded, and out_valid and out_data clear to 0.

Optional Feature:
SHIFT_SEQ_ROTATE_EN
- Defined:
  - Adds input port in_rot (1 bit), latched on accept.
  - When in_rot = 1, each step rotates instead of zero-filling, and n = in_amt mod WIDTH (no saturation).
  - When in_rot = 0, behaviour is the logical shift above.
- Undefined: port absent; logical shift only.

Decomposition:
- Package shift_ctrl_pkg holds:
  - state encodings ST_IDLE, ST_SHIFT, ST_DONE;
  - direction constants DIR_LEFT = 0, DIR_RIGHT = 1.
- Sub-module shift_step: combinational one-bit shifter.
  - Inputs: data, dir, (rot).
  - Output: data shifted one place.
  - Instantiated once in shift_sequencer.

Test Plan:
- Reset: rst high 2 cycles -> out_valid=0, out_data=0000, busy=0, in_ready=0 during reset, in_ready=1 the cycle after.
- Left shift: in_data=1101, in_amt=1, in_dir=0 -> out_data=1010, out_valid 2 cycles after accept. Then in_data=0011, in_amt=2, in_dir=0 -> 1100 after 3 cycles.
- Right shift and saturation:
  - 1101, amt=2, dir=1 -> 0011 after 3 cycles.
  - 1111, amt=7, dir=0 -> 0000 after 5 cycles.
  - 0011, amt=0 -> 0011 after 1 cycle.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> out_data stable, in_ready=0, concurrent in_valid ignored. Raise out_ready -> IDLE next cycle, new job accepted the cycle after.
- Reset mid-SHIFT: start 1101, amt=4, assert rst on 2nd SHIFT cycle -> IDLE next edge, out_valid=0, out_data=0000, no result produced.
- Rotate (with SHIFT_SEQ_ROTATE_EN): 1101, amt=1, dir=0, in_rot=1 -> 1011. 1101, amt=5, dir=1, in_rot=1 -> 1110 after 2 cycles.

Source files
------------

// File: rtl/shift_ctrl_pkg.sv
// Shared encodings for the shift sequencer: FSM state codes and shift-direction constants.
package shift_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_step.sv
// Combinational one-place shifter used as the per-cycle step of the shift sequencer.
// Optional macro SHIFT_SEQ_ROTATE_EN adds rot_i, which selects rotate instead of zero fill.
module shift_step
  import shift_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             dir_i,
`ifdef SHIFT_SEQ_ROTATE_EN
  input  logic             rot_i,
`endif
  output logic [WIDTH-1:0] data_o
);

  logic fill_left;   // bit entering at the LSB on a left step
  logic fill_right;  // bit entering at the MSB on a right step

  // Pick the fill bits: zero for a logical shift, the wrapped-out bit for a rotate.
  always_comb begin
    fill_left  = 1'b0;
    fill_right = 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
    if (rot_i) begin
      fill_left  = data_i[WIDTH-1];
      fill_right = data_i[0];
    end
`endif
  end

  // Single-place move in the requested direction.
  always_comb begin
    if (dir_i == DIR_RIGHT) begin
      data_o = {fill_right, data_i[WIDTH-1:1]};
    end else begin
      data_o = {data_i[WIDTH-2:0], fill_left};
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle variable-distance shifter: accepts a job, iterates a one-bit step per clock,
// then holds the result on out_data/out_valid until the consumer takes it.
// Optional macro SHIFT_SEQ_ROTATE_EN adds in_rot (rotate, amount taken modulo WIDTH).
module shift_sequencer
  import shift_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned SHAMT_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_amt,
  input  logic               in_dir,
`ifdef SHIFT_SEQ_ROTATE_EN
  input  logic               in_rot,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               busy
);

  // Must hold the value WIDTH itself (saturated amount).
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               dir_q, dir_d;
  logic [CntW-1:0]    count_q, count_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   step_data;
  int unsigned        amt_ext;
  int unsigned        n_eff;
`ifdef SHIFT_SEQ_ROTATE_EN
  logic               rot_q, rot_d;
`endif

  shift_step #(
    .WIDTH (WIDTH)
  ) u_shift_step (
    .data_i (work_q),
    .dir_i  (dir_q),
`ifdef SHIFT_SEQ_ROTATE_EN
    .rot_i  (rot_q),
`endif
    .data_o (step_data)
  );

  assign in_ready  = (state_q == ST_IDLE) & ~rst;
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // Effective step count: saturate at WIDTH for shifts, wrap modulo WIDTH for rotates.
  always_comb begin
    amt_ext = 32'(in_amt);
    n_eff   = (amt_ext >= WIDTH) ? WIDTH : amt_ext;
`ifdef SHIFT_SEQ_ROTATE_EN
    if (in_rot) n_eff = amt_ext % WIDTH;
`endif
  end

  // Next-state logic for the IDLE -> SHIFT -> DONE sequence and its registered outputs.
  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    dir_d       = dir_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
`ifdef SHIFT_SEQ_ROTATE_EN
    rot_d       = rot_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          work_d = in_data;
          dir_d  = in_dir;
`ifdef SHIFT_SEQ_ROTATE_EN
          rot_d  = in_rot;
`endif
          if (n_eff == 0) begin
            // Zero-distance job: result is the operand, presented next cycle.
            state_d     = ST_DONE;
            out_valid_d = 1'b1;
            out_data_d  = in_data;
          end else begin
            state_d = ST_SHIFT;
            count_d = CntW'(n_eff);
          end
        end
      end
      ST_SHIFT: begin
        work_d  = step_data;
        count_d = count_q - CntW'(1);
        if (count_q == CntW'(1)) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          out_data_d  = step_data;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset; reset discards any job in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      work_q      <= '0;
      dir_q       <= DIR_LEFT;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifdef SHIFT_SEQ_ROTATE_EN
      rot_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      dir_q       <= dir_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
`ifdef SHIFT_SEQ_ROTATE_EN
      rot_q       <= rot_d;
`endif
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed cases plus random jobs checked against
// an arithmetic reference model. Honours SHIFT_SEQ_ROTATE_EN when defined.
module tb_shift_sequencer;

  localparam int W  = 4;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [SW-1:0] in_amt;
  logic          in_dir;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          busy;
`ifdef SHIFT_SEQ_ROTATE_EN
  logic          in_rot;
  localparam bit HasRot = 1'b1;
`else
  localparam bit HasRot = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  logic [W-1:0] last_result;

  shift_sequencer #(
    .WIDTH   (W),
    .SHAMT_W (SW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_dir    (in_dir),
`ifdef SHIFT_SEQ_ROTATE_EN
    .in_rot    (in_rot),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Number of one-bit steps a job needs.
  function automatic int steps(input int amt, input bit rot);
    if (rot) return amt % W;
    return (amt < W) ? amt : W;
  endfunction

  // Reference result computed with plain wide shifts.
  function automatic logic [W-1:0] model(input logic [W-1:0] d, input int amt, input bit dir,
                                         input bit rot);
    logic [2*W-1:0] w;
    int n;
    n = steps(amt, rot);
    if (rot) begin
      w = {d, d};
      if (dir) begin
        w = w >> n;
        return w[W-1:0];
      end
      w = w << n;
      return w[2*W-1:W];
    end
    if (dir) return d >> n;
    w = {{W{1'b0}}, d} << n;
    return w[W-1:0];
  endfunction

  task automatic set_rot(input bit r);
`ifdef SHIFT_SEQ_ROTATE_EN
    in_rot = r;
`else
    if (r) $display("note: rotate requested without rotate support");
`endif
  endtask

  // Present a job at a negedge, let the accepting edge pass, drop in_valid.
  task automatic start_job(input string tag, input logic [W-1:0] d, input int amt, input bit dir,
                           input bit rot);
    check({tag, ":in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = amt[SW-1:0];
    in_dir   = dir;
    set_rot(rot);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = W'($urandom);
    in_amt   = SW'($urandom);
    in_dir   = 1'($urandom);
  endtask

  // Wait (bounded) for out_valid; latency counts the accepting edge as cycle 1.
  task automatic wait_result(input string tag, input logic [W-1:0] exp, input int exp_lat);
    int lat;
    lat = 1;
    while (!out_valid && lat < 20) begin
      check({tag, ":busy_shift"}, 32'(busy), 32'd1);
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({tag, ":latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ":out_data"}, 32'(out_data), 32'(exp));
    check({tag, ":in_ready_done"}, 32'(in_ready), 32'd0);
  endtask

  // Hold off the consumer for a while, then take the result.
  task automatic release_result(input string tag, input logic [W-1:0] exp, input int delay);
    for (int i = 0; i < delay; i++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, ":hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, ":hold_data"}, 32'(out_data), 32'(exp));
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ":valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, ":busy_idle"}, 32'(busy), 32'd0);
    check({tag, ":data_held"}, 32'(out_data), 32'(exp));
    last_result = exp;
  endtask

  task automatic run_job(input string tag, input logic [W-1:0] d, input int amt, input bit dir,
                         input bit rot, input int delay);
    logic [W-1:0] exp;
    exp = model(d, amt, dir, rot);
    start_job(tag, d, amt, dir, rot);
    wait_result(tag, exp, steps(amt, rot) + 1);
    release_result(tag, exp, delay);
  endtask

  initial begin
    logic [W-1:0] exp;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    in_dir    = 1'b0;
    out_ready = 1'b0;
    set_rot(1'b0);
    last_result = '0;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset:in_ready", 32'(in_ready), 32'd0);
    check("reset:out_valid", 32'(out_valid), 32'd0);
    check("reset:out_data", 32'(out_data), 32'd0);
    check("reset:busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("post_reset:in_ready", 32'(in_ready), 32'd1);

    // Directed shifts
    run_job("left1", 4'b1101, 1, 1'b0, 1'b0, 0);
    run_job("left2", 4'b0011, 2, 1'b0, 1'b0, 0);
    run_job("right2", 4'b1101, 2, 1'b1, 1'b0, 0);
    run_job("sat7", 4'b1111, 7, 1'b0, 1'b0, 0);
    run_job("amt0", 4'b0011, 0, 1'b0, 1'b0, 0);
    run_job("sat4r", 4'b1010, 4, 1'b1, 1'b0, 1);

    // Backpressure: new request during DONE is ignored, accepted only after handoff
    start_job("bp", 4'b1001, 1, 1'b1, 1'b0);
    wait_result("bp", 4'b0100, 2);
    in_valid = 1'b1;
    in_data  = 4'b0110;
    in_amt   = 3'd3;
    in_dir   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp:hold_valid", 32'(out_valid), 32'd1);
      check("bp:hold_data", 32'(out_data), 32'b0100);
      check("bp:hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp:handoff_idle", 32'(busy), 32'd0);
    check("bp:handoff_in_ready", 32'(in_ready), 32'd1);
    check("bp:handoff_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp:second_accepted", 32'(busy), 32'd1);
    exp = model(4'b0110, 3, 1'b0, 1'b0);
    wait_result("bp2", exp, 4);
    release_result("bp2", exp, 0);

    // Reset during the second SHIFT cycle
    start_job("midrst", 4'b1101, 4, 1'b0, 1'b0);
    check("midrst:busy1", 32'(busy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("midrst:busy2", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst:out_valid", 32'(out_valid), 32'd0);
    check("midrst:out_data", 32'(out_data), 32'd0);
    check("midrst:busy", 32'(busy), 32'd0);
    check("midrst:in_ready_rst", 32'(in_ready), 32'd0);
    rst = 1'b0;
    last_result = '0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("midrst:no_result", 32'(out_valid), 32'd0);
    end
    check("midrst:in_ready", 32'(in_ready), 32'd1);

`ifdef SHIFT_SEQ_ROTATE_EN
    run_job("rotl1", 4'b1101, 1, 1'b0, 1'b1, 0);
    run_job("rotr5", 4'b1101, 5, 1'b1, 1'b1, 0);
    run_job("rot4", 4'b1001, 4, 1'b0, 1'b1, 0);
`endif

    // Random jobs against the model
    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] d;
      int amt;
      bit dir;
      bit rot;
      d   = W'($urandom);
      amt = int'($urandom_range(0, 7));
      dir = 1'($urandom);
      rot = HasRot ? 1'($urandom) : 1'b0;
      check("rand:out_data_idle", 32'(out_data), 32'(last_result));
      run_job("rand", d, amt, dir, rot, int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so a stuck DUT still ends with a summary.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
